// File: rtl/tick_level_pkg.sv
// tick_level_pkg: shared types and helpers for tick_to_level_gen.
//   gen_state_t : pulse generator states (IDLE, HIGH, GAP)
//   cnt_width() : width of the shared high/gap down-counter
package tick_level_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    GAP
  } gen_state_t;

  // Counter must hold max(high_cycles, low_cycles) - 1; sized to the
  // larger phase length plus one so a value of 1 still gets a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned high_cycles,
                                            input int unsigned low_cycles);
    int unsigned m;
    m = (high_cycles > low_cycles) ? high_cycles : low_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tick_to_level_gen.sv
// tick_to_level_gen: turns single-cycle tick events into level pulses.
// Each accepted tick yields HIGH_CYCLES cycles of level=1 followed by at
// least LOW_CYCLES cycles of level=0, so a downstream rising-edge detector
// recovers one edge per accepted tick.
//
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  synchronous active-high reset
//   tick  in  one-cycle event request
//   level out registered pulse output (high only in HIGH)
//   busy  out registered, high in HIGH and GAP
//   drop  out registered one-cycle pulse, cycle after a tick is discarded
//
// Build option: define TICK_LEVEL_QUEUE_EN to queue up to PEND_DEPTH ticks
// that arrive while busy; otherwise such ticks are discarded.
module tick_to_level_gen
  import tick_level_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = 4,
  parameter int unsigned LOW_CYCLES  = 2,
  parameter int unsigned PEND_DEPTH  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic level,
  output logic busy,
  output logic drop
);

  localparam int unsigned CW = cnt_width(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [CW-1:0] HI_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LO_LOAD = CW'(LOW_CYCLES - 1);

  if (HIGH_CYCLES == 0 || LOW_CYCLES == 0 || PEND_DEPTH == 0) begin : g_bad_cfg
    $error("tick_to_level_gen: HIGH_CYCLES, LOW_CYCLES and PEND_DEPTH must be >= 1");
  end

  gen_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          drop_n;
  logic          queue_tick;

`ifdef TICK_LEVEL_QUEUE_EN
  localparam int unsigned PW = $clog2(PEND_DEPTH + 1);
  localparam logic [PW-1:0] PMAX = PW'(PEND_DEPTH);
  logic [PW-1:0] pending, pending_n;
`endif

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    drop_n     = 1'b0;
    queue_tick = 1'b0;
`ifdef TICK_LEVEL_QUEUE_EN
    pending_n  = pending;
`endif
    case (state)
      IDLE: begin
        if (tick) begin
          state_n = HIGH;
          cnt_n   = HI_LOAD;
        end
      end
      HIGH: begin
        queue_tick = tick;
        if (cnt == '0) begin
          state_n = GAP;
          cnt_n   = LO_LOAD;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_n      = cnt - CW'(1);
          queue_tick = tick;
        end else begin
`ifdef TICK_LEVEL_QUEUE_EN
          // A tick arriving with a non-empty queue is counted while the oldest
          // queued request is consumed, so pending nets out unchanged and
          // nothing is dropped even when the queue is full.
          if (pending != '0 || tick) begin
            state_n = HIGH;
            cnt_n   = HI_LOAD;
            if (pending != '0 && !tick)
              pending_n = pending - PW'(1);
          end else begin
            state_n = IDLE;
          end
`else
          if (tick) begin
            state_n = HIGH;
            cnt_n   = HI_LOAD;
          end else begin
            state_n = IDLE;
          end
`endif
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    if (queue_tick) begin
`ifdef TICK_LEVEL_QUEUE_EN
      if (pending < PMAX)
        pending_n = pending + PW'(1);
      else
        drop_n = 1'b1;
`else
      drop_n = 1'b1;
`endif
    end
  end

  // level/busy are registered from the next state so they line up with the
  // state register and have no combinational path from tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      level   <= 1'b0;
      busy    <= 1'b0;
      drop    <= 1'b0;
`ifdef TICK_LEVEL_QUEUE_EN
      pending <= '0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      level   <= (state_n == HIGH);
      busy    <= (state_n != IDLE);
      drop    <= drop_n;
`ifdef TICK_LEVEL_QUEUE_EN
      pending <= pending_n;
`endif
    end
  end

endmodule

// File: tb/tb_tick_to_level_gen.sv
// tb_tick_to_level_gen: directed self-checking bench for tick_to_level_gen
// with HIGH_CYCLES=4, LOW_CYCLES=2, PEND_DEPTH=3. Expectations follow the
// build option TICK_LEVEL_QUEUE_EN when it is defined for the bench too.
module tb_tick_to_level_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic level, busy, drop;

  int checks = 0;
  int errors = 0;

  // Per-cycle captures: index k is the value seen during cycle k of a run.
  logic [63:0] lv, bz, dr;
  int          pd [64];

  always #5 clk = ~clk;

  tick_to_level_gen #(
    .HIGH_CYCLES(4),
    .LOW_CYCLES (2),
    .PEND_DEPTH (3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .level(level),
    .busy (busy),
    .drop (drop)
  );

  function automatic logic [63:0] mask(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int edges(input logic [63:0] v);
    int e;
    e = v[0] ? 1 : 0;
    for (int i = 1; i < 64; i++) if (v[i] && !v[i-1]) e++;
    return e;
  endfunction

  task automatic do_reset();
    rst  = 1'b1;
    tick = 1'b0;
    @(posedge clk); #1;
    rst  = 1'b0;
  endtask

  // Cycle 0 is the cycle right after reset release; tv[k]/rv[k] are driven
  // during cycle k and sampled at the edge that ends it.
  task automatic run(input logic [63:0] tv, input logic [63:0] rv, input int n);
    lv = '0; bz = '0; dr = '0;
    for (int k = 0; k < 64; k++) pd[k] = 0;
    for (int k = 0; k < n; k++) begin
      lv[k] = level;
      bz[k] = busy;
      dr[k] = drop;
`ifdef TICK_LEVEL_QUEUE_EN
      pd[k] = int'(dut.pending);
`endif
      tick = tv[k];
      rst  = rv[k];
      @(posedge clk); #1;
    end
    tick = 1'b0;
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({level, busy, drop} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000", {level, busy, drop});
    end
    tick = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({level, busy, drop} !== 3'b000) begin
      errors++;
      $display("FAIL reset_tick_ignored got %b exp 000", {level, busy, drop});
    end
  endtask

  task automatic test_single();
    do_reset();
    run(64'h1, '0, 12);
    checks++;
    if (lv !== mask(1, 4)) begin
      errors++; $display("FAIL single_level got %h exp %h", lv, mask(1, 4));
    end
    checks++;
    if (bz !== mask(1, 6)) begin
      errors++; $display("FAIL single_busy got %h exp %h", bz, mask(1, 6));
    end
    checks++;
    if (dr !== '0) begin
      errors++; $display("FAIL single_drop got %h exp 0", dr);
    end
    checks++;
    if (edges(lv) != 1) begin
      errors++; $display("FAIL single_edges got %0d exp 1", edges(lv));
    end
  endtask

  task automatic test_two();
    logic [63:0] el, ed;
`ifdef TICK_LEVEL_QUEUE_EN
    el = mask(1, 4) | mask(7, 10);
    ed = '0;
`else
    el = mask(1, 4);
    ed = mask(2, 2);
`endif
    do_reset();
    run(64'h3, '0, 14);
    checks++;
    if (lv !== el) begin
      errors++; $display("FAIL two_level got %h exp %h", lv, el);
    end
    checks++;
    if (dr !== ed) begin
      errors++; $display("FAIL two_drop got %h exp %h", dr, ed);
    end
`ifdef TICK_LEVEL_QUEUE_EN
    checks++;
    if (pd[2] != 1 || pd[7] != 0) begin
      errors++; $display("FAIL two_pending got %0d/%0d exp 1/0", pd[2], pd[7]);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [63:0] el, eb, ed;
`ifdef TICK_LEVEL_QUEUE_EN
    el = mask(1, 4) | mask(7, 10) | mask(13, 16) | mask(19, 22);
    eb = mask(1, 24);
    ed = mask(5, 6);
`else
    el = mask(1, 4);
    eb = mask(1, 6);
    ed = mask(2, 6);
`endif
    do_reset();
    run(64'h3F, '0, 28);
    checks++;
    if (lv !== el) begin
      errors++; $display("FAIL burst_level got %h exp %h", lv, el);
    end
    checks++;
    if (bz !== eb) begin
      errors++; $display("FAIL burst_busy got %h exp %h", bz, eb);
    end
    checks++;
    if (dr !== ed) begin
      errors++; $display("FAIL burst_drop got %h exp %h", dr, ed);
    end
`ifdef TICK_LEVEL_QUEUE_EN
    checks++;
    if (pd[4] != 3) begin
      errors++; $display("FAIL burst_pending got %0d exp 3", pd[4]);
    end
`endif
  endtask

  task automatic test_last_gap();
    logic [63:0] el, ed;
`ifdef TICK_LEVEL_QUEUE_EN
    el = mask(1, 4) | mask(7, 10) | mask(13, 16);
    ed = '0;
`else
    el = mask(1, 4) | mask(7, 10);
    ed = mask(3, 3);
`endif
    do_reset();
    run(64'h45, '0, 20);
    checks++;
    if (lv !== el) begin
      errors++; $display("FAIL lastgap_level got %h exp %h", lv, el);
    end
    checks++;
    if (dr !== ed) begin
      errors++; $display("FAIL lastgap_drop got %h exp %h", dr, ed);
    end
  endtask

  task automatic test_reset_abort();
    logic [63:0] ed;
`ifdef TICK_LEVEL_QUEUE_EN
    ed = '0;
`else
    ed = mask(2, 2);
`endif
    do_reset();
    run(64'h23, 64'h4, 12);
    checks++;
    if (lv !== (mask(1, 2) | mask(6, 9))) begin
      errors++; $display("FAIL abort_level got %h exp %h", lv, mask(1, 2) | mask(6, 9));
    end
    checks++;
    if (bz !== (mask(1, 2) | mask(6, 11))) begin
      errors++; $display("FAIL abort_busy got %h exp %h", bz, mask(1, 2) | mask(6, 11));
    end
    checks++;
    if (dr !== ed) begin
      errors++; $display("FAIL abort_drop got %h exp %h", dr, ed);
    end
`ifdef TICK_LEVEL_QUEUE_EN
    checks++;
    if (pd[2] != 1 || pd[3] != 0) begin
      errors++; $display("FAIL abort_pending got %0d/%0d exp 1/0", pd[2], pd[3]);
    end
`endif
  endtask

  task automatic test_full_last_gap();
    logic [63:0] tv, el, eb;
    int          ee;
`ifdef TICK_LEVEL_QUEUE_EN
    tv = 64'h4F;
    el = mask(1, 4) | mask(7, 10) | mask(13, 16) | mask(19, 22) | mask(25, 28);
    eb = mask(1, 30);
    ee = 5;
`else
    tv = 64'h1041;
    el = mask(1, 4) | mask(7, 10) | mask(13, 16);
    eb = mask(1, 18);
    ee = 3;
`endif
    do_reset();
    run(tv, '0, 34);
    checks++;
    if (lv !== el) begin
      errors++; $display("FAIL full_level got %h exp %h", lv, el);
    end
    checks++;
    if (bz !== eb) begin
      errors++; $display("FAIL full_busy got %h exp %h", bz, eb);
    end
    checks++;
    if (dr !== '0) begin
      errors++; $display("FAIL full_drop got %h exp 0", dr);
    end
    checks++;
    if (edges(lv) != ee) begin
      errors++; $display("FAIL full_edges got %0d exp %0d", edges(lv), ee);
    end
`ifdef TICK_LEVEL_QUEUE_EN
    checks++;
    if (pd[4] != 3 || pd[7] != 3) begin
      errors++; $display("FAIL full_pending got %0d/%0d exp 3/3", pd[4], pd[7]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_back_to_back();
    test_last_gap();
    test_reset_abort();
    test_full_last_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
